// File: rtl/ahb2apb_bridge_px_if.sv
// Bus bundle for the AHB-Lite to APB bridge: AHB address/data phase plus the APB requester side.
// The bridge uses the slave modport; whoever drives AHB and answers on APB uses master.
interface ahb2apb_bridge_px_if #(
   parameter int AW   = 32,
   parameter int DW   = 32,
   parameter int NSLV = 4
);
   logic [1:0]      Htrans;
   logic            Hwrite;
   logic [2:0]      Hsize;
   logic [2:0]      Hburst;
   logic [AW-1:0]   Haddr;
   logic [DW-1:0]   Hwdata;
   logic            Hreadyin;
   logic            Hreadyout;
   logic [1:0]      Hresp;
   logic [DW-1:0]   Hrdata;

   logic [NSLV-1:0] Pselx;
   logic            Penable;
   logic            Pwrite;
   logic [AW-1:0]   Paddr;
   logic [DW-1:0]   Pwdata;
   logic [DW/8-1:0] Pstrb;
   logic [DW-1:0]   Prdata;
   logic            Pready;
   logic            Pslverr;

   modport slave (
      input  Htrans, Hwrite, Hsize, Hburst, Haddr, Hwdata, Hreadyin,
      output Hreadyout, Hresp, Hrdata,
      output Pselx, Penable, Pwrite, Paddr, Pwdata, Pstrb,
      input  Prdata, Pready, Pslverr
   );

   modport master (
      output Htrans, Hwrite, Hsize, Hburst, Haddr, Hwdata, Hreadyin,
      input  Hreadyout, Hresp, Hrdata,
      input  Pselx, Penable, Pwrite, Paddr, Pwdata, Pstrb,
      output Prdata, Pready, Pslverr
   );
endinterface

// File: rtl/ahb2apb_bridge_px.sv
// AHB-Lite to APB bridge: each accepted AHB beat becomes one APB SETUP/ACCESS transfer,
// with address decode, byte strobes, Pready timeout and a two-cycle AHB ERROR response.
module ahb2apb_bridge_px #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int NSLV    = 4,
   parameter int SEL_LSB = 12,
   parameter int TIMEOUT = 255
) (
   input logic                Hclk,
   input logic                Hresetn,
   ahb2apb_bridge_px_if.slave bus
);

   localparam int BW = DW / 8;
   localparam int BL = $clog2(BW);
   localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TLAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETUP  = 3'd1;
   localparam logic [2:0] S_ACCESS = 3'd2;
   localparam logic [2:0] S_ERR1   = 3'd3;
   localparam logic [2:0] S_ERR2   = 3'd4;

   logic [2:0]      state;
   logic [2:0]      nxt;
   logic [TW-1:0]   tcnt;
   logic [NSLV-1:0] sel_q;
   logic [AW-1:0]   paddr_q;
   logic            pwrite_q;
   logic [BW-1:0]   pstrb_q;
   logic [DW-1:0]   pwdata_q;
   logic [DW-1:0]   hrdata_q;

   logic            ready_out;
   logic            accept;
   logic            hit;
   logic            size_ok;
   logic [SW-1:0]   idx;
   logic [AW-1:0]   hi_bits;
   logic [BL-1:0]   boff;
   logic [NSLV-1:0] sel_nxt;
   logic [BW-1:0]   strb_nxt;
   logic            unused_bits;

   // Hburst is ignored (every beat stands alone) and Htrans[1] alone separates NONSEQ/SEQ from IDLE/BUSY.
   assign unused_bits = ^{bus.Hburst, bus.Htrans[0]};

   assign ready_out = (state == S_IDLE) || (state == S_ERR2);
   assign accept    = bus.Hreadyin && ready_out && bus.Htrans[1];

   // Any set address bit above the slave-index field is a decode miss, as is an index past NSLV.
   assign idx     = bus.Haddr[SEL_LSB +: SW];
   assign hi_bits = bus.Haddr >> (SEL_LSB + SW);
   assign hit     = (hi_bits == '0) && (int'(idx) < NSLV);
   assign size_ok = (int'(bus.Hsize) <= BL);
   assign boff    = bus.Haddr[BL-1:0];

   // A byte lane is strobed when it falls in the same size-aligned block as the address.
   always_comb begin
      sel_nxt  = '0;
      strb_nxt = '0;
      for (int i = 0; i < NSLV; i++) begin
         sel_nxt[i] = (int'(idx) == i);
      end
      for (int b = 0; b < BW; b++) begin
         strb_nxt[b] = bus.Hwrite && ((b >> bus.Hsize) == (int'(boff) >> bus.Hsize));
      end
   end

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE, S_ERR2: begin
            if (accept) begin
               nxt = (hit && size_ok) ? S_SETUP : S_ERR1;
            end else begin
               nxt = S_IDLE;
            end
         end
         S_SETUP:  nxt = S_ACCESS;
         S_ACCESS: begin
            if (bus.Pready) begin
               nxt = bus.Pslverr ? S_ERR1 : S_IDLE;
            end else if ((TIMEOUT > 0) && (tcnt == TLAST)) begin
               nxt = S_ERR1;
            end
         end
         S_ERR1:   nxt = S_ERR2;
         default:  nxt = S_IDLE;
      endcase
   end

   // Address-phase values are captured on every acceptance; Pwdata is latched at the end of SETUP.
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         state    <= S_IDLE;
         tcnt     <= '0;
         sel_q    <= '0;
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         pstrb_q  <= '0;
         pwdata_q <= '0;
         hrdata_q <= '0;
      end else begin
         state <= nxt;
         if ((state == S_ACCESS) && (nxt == S_ACCESS)) begin
            tcnt <= tcnt + TW'(1);
         end else begin
            tcnt <= '0;
         end
         if (accept) begin
            paddr_q  <= bus.Haddr;
            pwrite_q <= bus.Hwrite;
            pstrb_q  <= strb_nxt;
            sel_q    <= (hit && size_ok) ? sel_nxt : '0;
         end
         if (state == S_SETUP) begin
            pwdata_q <= bus.Hwdata;
         end
         if ((state == S_ACCESS) && bus.Pready && !bus.Pslverr && !pwrite_q) begin
            hrdata_q <= bus.Prdata;
         end
      end
   end

   // AHB write data only arrives in the SETUP cycle, so it is passed straight through there.
   assign bus.Hreadyout = ready_out;
   assign bus.Hresp     = ((state == S_ERR1) || (state == S_ERR2)) ? 2'b01 : 2'b00;
   assign bus.Hrdata    = hrdata_q;
   assign bus.Pselx     = ((state == S_SETUP) || (state == S_ACCESS)) ? sel_q : '0;
   assign bus.Penable   = (state == S_ACCESS);
   assign bus.Pwrite    = pwrite_q;
   assign bus.Paddr     = paddr_q;
   assign bus.Pstrb     = pstrb_q;
   assign bus.Pwdata    = (state == S_SETUP) ? bus.Hwdata : pwdata_q;

endmodule

// File: tb/tb_ahb2apb_bridge_px.sv
// Directed bench for ahb2apb_bridge_px: write, waited read, decode/size errors, slave error,
// timeout, back-to-back transfers and mid-transfer reset, checked cycle by cycle.
module tb_ahb2apb_bridge_px;

   logic Hclk;
   logic Hresetn;
   int   compared;
   int   mismatched;

   ahb2apb_bridge_px_if #(.AW(32), .DW(32), .NSLV(4)) bus ();

   ahb2apb_bridge_px #(
      .AW(32), .DW(32), .NSLV(4), .SEL_LSB(12), .TIMEOUT(4)
   ) dut (
      .Hclk    (Hclk),
      .Hresetn (Hresetn),
      .bus     (bus)
   );

   initial Hclk = 1'b0;
   always #5 Hclk = ~Hclk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge Hclk);
      #1;
   endtask

   // Drives a NONSEQ beat; it is accepted at the next rising edge if the bridge is ready.
   task automatic applyStimulus(input logic wr, input logic [2:0] sz, input logic [31:0] addr);
      bus.Htrans = 2'b10;
      bus.Hwrite = wr;
      bus.Hsize  = sz;
      bus.Haddr  = addr;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_hreadyout"}, 64'(bus.Hreadyout), 64'h1);
      checkOutput({tag, "_hresp"},     64'(bus.Hresp),     64'h0);
      checkOutput({tag, "_hrdata"},    64'(bus.Hrdata),    64'h0);
      checkOutput({tag, "_pselx"},     64'(bus.Pselx),     64'h0);
      checkOutput({tag, "_penable"},   64'(bus.Penable),   64'h0);
      checkOutput({tag, "_pwrite"},    64'(bus.Pwrite),    64'h0);
      checkOutput({tag, "_paddr"},     64'(bus.Paddr),     64'h0);
      checkOutput({tag, "_pwdata"},    64'(bus.Pwdata),    64'h0);
      checkOutput({tag, "_pstrb"},     64'(bus.Pstrb),     64'h0);
   endtask

   initial begin
      compared     = 0;
      mismatched   = 0;
      Hresetn      = 1'b0;
      bus.Htrans   = 2'b00;
      bus.Hwrite   = 1'b0;
      bus.Hsize    = 3'd0;
      bus.Hburst   = 3'd0;
      bus.Haddr    = '0;
      bus.Hwdata   = '0;
      bus.Hreadyin = 1'b1;
      bus.Prdata   = '0;
      bus.Pready   = 1'b1;
      bus.Pslverr  = 1'b0;
      #2;
      checkResetValues("reset");
      #21;
      Hresetn = 1'b1;

      // Zero-wait word write to slave 1.
      tick();
      applyStimulus(1'b1, 3'd2, 32'h0000_1004);
      checkOutput("wr_idle_ready", 64'(bus.Hreadyout), 64'h1);
      tick();
      bus.Htrans = 2'b00;
      bus.Hwdata = 32'hA5A5_0001;
      #1;
      checkOutput("wr_setup_ready", 64'(bus.Hreadyout), 64'h0);
      checkOutput("wr_setup_pselx", 64'(bus.Pselx), 64'b0010);
      checkOutput("wr_setup_penable", 64'(bus.Penable), 64'h0);
      checkOutput("wr_setup_pstrb", 64'(bus.Pstrb), 64'b1111);
      checkOutput("wr_setup_paddr", 64'(bus.Paddr), 64'h1004);
      checkOutput("wr_setup_pwrite", 64'(bus.Pwrite), 64'h1);
      checkOutput("wr_setup_pwdata", 64'(bus.Pwdata), 64'hA5A5_0001);
      tick();
      bus.Hwdata = 32'h0;
      #1;
      checkOutput("wr_access_ready", 64'(bus.Hreadyout), 64'h0);
      checkOutput("wr_access_penable", 64'(bus.Penable), 64'h1);
      checkOutput("wr_access_pselx", 64'(bus.Pselx), 64'b0010);
      checkOutput("wr_access_pwdata", 64'(bus.Pwdata), 64'hA5A5_0001);
      tick();
      checkOutput("wr_done_ready", 64'(bus.Hreadyout), 64'h1);
      checkOutput("wr_done_hresp", 64'(bus.Hresp), 64'h0);
      checkOutput("wr_done_pselx", 64'(bus.Pselx), 64'h0);

      // Word read from slave 3 with Pready low for three ACCESS cycles.
      bus.Pready = 1'b0;
      bus.Prdata = 32'hDEAD_BEEF;
      applyStimulus(1'b0, 3'd2, 32'h0000_3008);
      tick();
      bus.Htrans = 2'b00;
      #1;
      checkOutput("rd_setup_pselx", 64'(bus.Pselx), 64'b1000);
      checkOutput("rd_setup_pstrb", 64'(bus.Pstrb), 64'h0);
      checkOutput("rd_setup_pwrite", 64'(bus.Pwrite), 64'h0);
      checkOutput("rd_wait1", 64'(bus.Hreadyout), 64'h0);
      tick();
      checkOutput("rd_wait2", 64'(bus.Hreadyout), 64'h0);
      tick();
      checkOutput("rd_wait3", 64'(bus.Hreadyout), 64'h0);
      tick();
      checkOutput("rd_wait4", 64'(bus.Hreadyout), 64'h0);
      checkOutput("rd_wait4_penable", 64'(bus.Penable), 64'h1);
      tick();
      bus.Pready = 1'b1;
      #1;
      checkOutput("rd_wait5", 64'(bus.Hreadyout), 64'h0);
      checkOutput("rd_hrdata_held", 64'(bus.Hrdata), 64'h0);
      tick();
      checkOutput("rd_done_ready", 64'(bus.Hreadyout), 64'h1);
      checkOutput("rd_done_hrdata", 64'(bus.Hrdata), 64'hDEAD_BEEF);
      checkOutput("rd_done_hresp", 64'(bus.Hresp), 64'h0);

      // Decode miss: index 5 with four slaves.
      applyStimulus(1'b0, 3'd2, 32'h0000_5000);
      tick();
      bus.Htrans = 2'b00;
      #1;
      checkOutput("miss_err1_hresp", 64'(bus.Hresp), 64'h1);
      checkOutput("miss_err1_ready", 64'(bus.Hreadyout), 64'h0);
      checkOutput("miss_err1_pselx", 64'(bus.Pselx), 64'h0);
      tick();
      checkOutput("miss_err2_hresp", 64'(bus.Hresp), 64'h1);
      checkOutput("miss_err2_ready", 64'(bus.Hreadyout), 64'h1);
      checkOutput("miss_err2_pselx", 64'(bus.Pselx), 64'h0);
      tick();
      checkOutput("miss_idle_hresp", 64'(bus.Hresp), 64'h0);
      checkOutput("miss_hrdata_kept", 64'(bus.Hrdata), 64'hDEAD_BEEF);

      // Byte write to offset 3, completed by the slave with Pslverr.
      bus.Pslverr = 1'b1;
      applyStimulus(1'b1, 3'd0, 32'h0000_0003);
      tick();
      bus.Htrans = 2'b00;
      bus.Hwdata = 32'h1122_3344;
      #1;
      checkOutput("byte_setup_pstrb", 64'(bus.Pstrb), 64'b1000);
      checkOutput("byte_setup_pselx", 64'(bus.Pselx), 64'b0001);
      tick();
      checkOutput("byte_access_penable", 64'(bus.Penable), 64'h1);
      tick();
      checkOutput("slverr_err1_hresp", 64'(bus.Hresp), 64'h1);
      checkOutput("slverr_err1_ready", 64'(bus.Hreadyout), 64'h0);
      checkOutput("slverr_err1_pselx", 64'(bus.Pselx), 64'h0);
      tick();
      bus.Pslverr = 1'b0;
      checkOutput("slverr_err2_hresp", 64'(bus.Hresp), 64'h1);
      checkOutput("slverr_err2_ready", 64'(bus.Hreadyout), 64'h1);
      // Illegal 64-bit size accepted straight out of ERR2.
      applyStimulus(1'b1, 3'd3, 32'h0000_2000);
      tick();
      bus.Htrans = 2'b00;
      #1;
      checkOutput("size_err1_hresp", 64'(bus.Hresp), 64'h1);
      checkOutput("size_err1_ready", 64'(bus.Hreadyout), 64'h0);
      checkOutput("size_err1_pselx", 64'(bus.Pselx), 64'h0);
      tick();
      checkOutput("size_err2_ready", 64'(bus.Hreadyout), 64'h1);
      tick();
      checkOutput("size_idle_hresp", 64'(bus.Hresp), 64'h0);

      // Timeout after four ACCESS cycles with Pready held low.
      bus.Pready = 1'b0;
      applyStimulus(1'b0, 3'd2, 32'h0000_2010);
      tick();
      bus.Htrans = 2'b00;
      #1;
      checkOutput("to_setup_pselx", 64'(bus.Pselx), 64'b0100);
      tick();
      tick();
      tick();
      tick();
      checkOutput("to_access4_pselx", 64'(bus.Pselx), 64'b0100);
      checkOutput("to_access4_penable", 64'(bus.Penable), 64'h1);
      tick();
      checkOutput("to_err1_pselx", 64'(bus.Pselx), 64'h0);
      checkOutput("to_err1_penable", 64'(bus.Penable), 64'h0);
      checkOutput("to_err1_hresp", 64'(bus.Hresp), 64'h1);
      checkOutput("to_err1_ready", 64'(bus.Hreadyout), 64'h0);
      tick();
      checkOutput("to_err2_hresp", 64'(bus.Hresp), 64'h1);
      checkOutput("to_err2_ready", 64'(bus.Hreadyout), 64'h1);
      bus.Pready = 1'b1;
      applyStimulus(1'b1, 3'd2, 32'h0000_1000);
      tick();
      bus.Htrans = 2'b00;
      bus.Hwdata = 32'hCAFE_0001;
      #1;
      checkOutput("after_to_setup_pselx", 64'(bus.Pselx), 64'b0010);
      checkOutput("after_to_setup_hresp", 64'(bus.Hresp), 64'h0);
      tick();
      tick();
      checkOutput("after_to_done_ready", 64'(bus.Hreadyout), 64'h1);
      checkOutput("after_to_hrdata_kept", 64'(bus.Hrdata), 64'hDEAD_BEEF);

      // Back-to-back writes, then reset pulsed in the middle of the second ACCESS.
      applyStimulus(1'b1, 3'd2, 32'h0000_0100);
      tick();
      bus.Htrans = 2'b00;
      bus.Hwdata = 32'h0101_0101;
      #1;
      checkOutput("b2b_first_pselx", 64'(bus.Pselx), 64'b0001);
      tick();
      checkOutput("b2b_first_access", 64'(bus.Penable), 64'h1);
      tick();
      checkOutput("b2b_first_done", 64'(bus.Hreadyout), 64'h1);
      bus.Pready = 1'b0;
      applyStimulus(1'b1, 3'd1, 32'h0000_3100);
      tick();
      bus.Htrans = 2'b00;
      bus.Hwdata = 32'h0000_BEEF;
      #1;
      checkOutput("b2b_second_pselx", 64'(bus.Pselx), 64'b1000);
      checkOutput("b2b_second_pstrb", 64'(bus.Pstrb), 64'b0011);
      checkOutput("b2b_second_ready", 64'(bus.Hreadyout), 64'h0);
      tick();
      checkOutput("b2b_second_penable", 64'(bus.Penable), 64'h1);
      #1;
      Hresetn = 1'b0;
      #1;
      checkResetValues("midreset");
      #2;
      Hresetn = 1'b1;
      tick();
      checkOutput("post_reset_ready", 64'(bus.Hreadyout), 64'h1);
      checkOutput("post_reset_pselx", 64'(bus.Pselx), 64'h0);

      // Plain read after reset release behaves as from IDLE.
      bus.Pready = 1'b1;
      bus.Prdata = 32'h1234_5678;
      applyStimulus(1'b0, 3'd2, 32'h0000_1000);
      tick();
      bus.Htrans = 2'b00;
      #1;
      checkOutput("post_rd_setup_pselx", 64'(bus.Pselx), 64'b0010);
      tick();
      checkOutput("post_rd_access_ready", 64'(bus.Hreadyout), 64'h0);
      tick();
      checkOutput("post_rd_done_ready", 64'(bus.Hreadyout), 64'h1);
      checkOutput("post_rd_hrdata", 64'(bus.Hrdata), 64'h1234_5678);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
